// File: rtl/enemies_pkg.sv
// enemies_pkg
//   Shared types and constants for the enemy drawing layer.
//   enemy_state_t : per-enemy life state (alive -> dying -> dead)
//   ENEMIES_MAX   : largest supported enemy count
//   BLINK_CNT_W   : width of the per-enemy death-blink frame counter
package enemies_pkg;

    typedef enum logic [1:0] {
        EN_ALIVE,
        EN_DYING,
        EN_DEAD
    } enemy_state_t;

    localparam int unsigned ENEMIES_MAX = 8;
    localparam int unsigned BLINK_CNT_W = 8;

endpackage

// File: rtl/enemy_life_fsm.sv
// enemy_life_fsm
//   Life state machine for one enemy: ALIVE, then DYING (frame-counted blink),
//   then DEAD. A level re-arm forces ALIVE and clears the blink counter.
//   Build option: ENEMIES_BLINK_EN selects the DYING/blink behaviour; when it is
//   undefined a kill goes straight to DEAD and the blink parameters are ignored.
// Ports
//   clk          : pixel clock
//   reset        : synchronous, active-high
//   rearm        : level start, forces ALIVE (wins over kill)
//   kill         : kill pulse, honoured only while ALIVE
//   startOfFrame : one-cycle pulse per frame, paces the blink countdown
//   state        : current life state
//   visible      : enemy may be drawn at this pixel
module enemy_life_fsm
    import enemies_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = 16,
    parameter int unsigned BLINK_PERIOD = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rearm,
    input  logic         kill,
    input  logic         startOfFrame,
    output enemy_state_t state,
    output logic         visible
);

    enemy_state_t state_q, state_d;

`ifdef ENEMIES_BLINK_EN
    localparam int unsigned PHASE_BIT = $clog2(BLINK_PERIOD);
    localparam logic [BLINK_CNT_W-1:0] CNT_LOAD = BLINK_CNT_W'(BLINK_FRAMES);

    logic [BLINK_CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EN_ALIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (rearm) begin
            state_d = EN_ALIVE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                EN_ALIVE: begin
                    if (kill) begin
                        state_d = EN_DYING;
                        cnt_d   = CNT_LOAD;
                    end
                end
                EN_DYING: begin
                    // Kills are ignored here so the blink never restarts.
                    if (startOfFrame) begin
                        if (cnt_q == BLINK_CNT_W'(1)) state_d = EN_DEAD;
                        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            EN_ALIVE: visible = 1'b1;
            EN_DYING: visible = ~cnt_q[PHASE_BIT];
            default:  visible = 1'b0;
        endcase
    end
`else
    localparam int unsigned UNUSED_BLINK_CFG = BLINK_FRAMES + BLINK_PERIOD;
    logic unused_sof;
    assign unused_sof = startOfFrame;

    always_ff @(posedge clk) begin
        if (reset) state_q <= EN_ALIVE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (rearm)                            state_d = EN_ALIVE;
        else if (state_q == EN_ALIVE && kill) state_d = EN_DEAD;
    end

    assign visible = (state_q == EN_ALIVE);
`endif

    assign state = state_q;

endmodule

// File: rtl/enemies_layer_mux.sv
// enemies_layer_mux
//   Merges N enemy draw requests into one priority-resolved RGB/DR pair and a
//   one-hot collision bus, tracks per-enemy life state and reports alive status
//   and a level-cleared pulse.
//   Build option: ENEMIES_BLINK_EN enables the dying/blink phase (see
//   enemy_life_fsm); undefined, a kill removes the enemy immediately.
// Ports
//   clk, reset     : pixel clock, synchronous active-high reset
//   game_on        : level running; its rising edge re-arms all enemies
//   startOfFrame   : one-cycle frame pulse
//   enemyDR        : per-enemy draw request
//   enemyRGB       : per-enemy colour, enemy i at [i*RGB_W +: RGB_W]
//   enemy_kill     : per-enemy kill pulse
//   enemiesDR      : some visible enemy covers this pixel
//   enemiesRGB     : colour of the winning (lowest-index visible) enemy, else 0
//   enemiesDR_BUS  : one-hot winner, only when the winner is ALIVE
//   alive_mask     : registered per-enemy ALIVE flags
//   alive_count    : popcount of alive_mask
//   level_clear    : one-cycle pulse once the last enemy is DEAD
module enemies_layer_mux
    import enemies_pkg::*;
#(
    parameter int unsigned N_ENEMIES    = 3,
    parameter int unsigned RGB_W        = 8,
    parameter int unsigned BLINK_FRAMES = 16,
    parameter int unsigned BLINK_PERIOD = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             game_on,
    input  logic                             startOfFrame,
    input  logic [N_ENEMIES-1:0]             enemyDR,
    input  logic [N_ENEMIES*RGB_W-1:0]       enemyRGB,
    input  logic [N_ENEMIES-1:0]             enemy_kill,
    output logic                             enemiesDR,
    output logic [RGB_W-1:0]                 enemiesRGB,
    output logic [N_ENEMIES-1:0]             enemiesDR_BUS,
    output logic [N_ENEMIES-1:0]             alive_mask,
    output logic [$clog2(N_ENEMIES+1)-1:0]   alive_count,
    output logic                             level_clear
);

    localparam int unsigned CNT_W = $clog2(N_ENEMIES + 1);

    logic                 game_on_d;
    logic                 rearm;
    logic                 any_live_d;
    logic                 armed;
    logic                 hit;
    enemy_state_t         st [N_ENEMIES];
    logic [N_ENEMIES-1:0] vis;
    logic [N_ENEMIES-1:0] is_alive;
    logic [N_ENEMIES-1:0] non_dead;

    assign rearm = game_on & ~game_on_d;

    for (genvar g = 0; g < N_ENEMIES; g++) begin : g_enemy
        enemy_life_fsm #(
            .BLINK_FRAMES (BLINK_FRAMES),
            .BLINK_PERIOD (BLINK_PERIOD)
        ) u_fsm (
            .clk          (clk),
            .reset        (reset),
            .rearm        (rearm),
            .kill         (enemy_kill[g]),
            .startOfFrame (startOfFrame),
            .state        (st[g]),
            .visible      (vis[g])
        );
        assign is_alive[g] = (st[g] == EN_ALIVE);
        assign non_dead[g] = (st[g] != EN_DEAD);
    end

    // Lowest visible index wins; a dying winner is drawn but does not collide.
    always_comb begin
        hit           = 1'b0;
        enemiesRGB    = '0;
        enemiesDR_BUS = '0;
        for (int unsigned i = 0; i < N_ENEMIES; i++) begin
            if (!hit && enemyDR[i] && vis[i]) begin
                hit              = 1'b1;
                enemiesRGB       = enemyRGB[i*RGB_W +: RGB_W];
                enemiesDR_BUS[i] = is_alive[i];
            end
        end
        enemiesDR = hit;
    end

    always_comb begin
        alive_count = '0;
        for (int unsigned i = 0; i < N_ENEMIES; i++)
            alive_count = alive_count + CNT_W'(alive_mask[i]);
    end

    // level_clear compares last cycle's "any non-dead" with now, so a group of
    // simultaneous deaths yields a single pulse. armed records that enemies
    // were made ALIVE (by reset or re-arm) since reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            game_on_d   <= 1'b0;
            alive_mask  <= '1;
            any_live_d  <= 1'b1;
            armed       <= 1'b1;
            level_clear <= 1'b0;
        end else begin
            game_on_d   <= game_on;
            alive_mask  <= is_alive;
            any_live_d  <= |non_dead;
            if (rearm) armed <= 1'b1;
            level_clear <= armed & any_live_d & ~(|non_dead);
        end
    end

endmodule

// File: tb/tb_enemies_layer_mux.sv
// tb_enemies_layer_mux
//   Directed bench for enemies_layer_mux: a 3-enemy instance (blink 4 frames,
//   period 1) and an 8-enemy instance with default blink settings. Expected
//   values follow the build option ENEMIES_BLINK_EN.
module tb_enemies_layer_mux;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // 3-enemy instance
    logic        a_game_on, a_sof;
    logic [2:0]  a_dr, a_kill;
    logic [23:0] a_rgb;
    logic        a_edr, a_lc;
    logic [7:0]  a_ergb;
    logic [2:0]  a_bus, a_mask;
    logic [1:0]  a_cnt;

    // 8-enemy instance
    logic        b_game_on, b_sof;
    logic [7:0]  b_dr, b_kill;
    logic [63:0] b_rgb;
    logic        b_edr, b_lc;
    logic [7:0]  b_ergb;
    logic [7:0]  b_bus, b_mask;
    logic [3:0]  b_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int pulses;

    enemies_layer_mux #(
        .N_ENEMIES    (3),
        .RGB_W        (8),
        .BLINK_FRAMES (4),
        .BLINK_PERIOD (1)
    ) dut_a (
        .clk           (clk),
        .reset         (reset),
        .game_on       (a_game_on),
        .startOfFrame  (a_sof),
        .enemyDR       (a_dr),
        .enemyRGB      (a_rgb),
        .enemy_kill    (a_kill),
        .enemiesDR     (a_edr),
        .enemiesRGB    (a_ergb),
        .enemiesDR_BUS (a_bus),
        .alive_mask    (a_mask),
        .alive_count   (a_cnt),
        .level_clear   (a_lc)
    );

    enemies_layer_mux #(
        .N_ENEMIES (8),
        .RGB_W     (8)
    ) dut_b (
        .clk           (clk),
        .reset         (reset),
        .game_on       (b_game_on),
        .startOfFrame  (b_sof),
        .enemyDR       (b_dr),
        .enemyRGB      (b_rgb),
        .enemy_kill    (b_kill),
        .enemiesDR     (b_edr),
        .enemiesRGB    (b_ergb),
        .enemiesDR_BUS (b_bus),
        .alive_mask    (b_mask),
        .alive_count   (b_cnt),
        .level_clear   (b_lc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_a_sof();
        a_sof = 1'b1;
        step();
        a_sof = 1'b0;
        #1;
    endtask

    task automatic pulse_b_sof();
        b_sof = 1'b1;
        step();
        b_sof = 1'b0;
        #1;
    endtask

    task automatic kill_a(input logic [2:0] k);
        a_kill = k;
        step();
        a_kill = '0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        a_game_on = 1'b0; a_sof = 1'b0; a_dr = '0; a_kill = '0; a_rgb = '0;
        b_game_on = 1'b0; b_sof = 1'b0; b_dr = '0; b_kill = '0; b_rgb = '0;
        step();
        step();
        reset = 1'b0;

        // ---- 8-enemy instance: kill 0..6, enemy 7 wins, then mid-level reset
        b_dr  = 8'hFF;
        b_rgb = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        #1;
        check("b_reset_mask", b_mask, 8'hFF);
        check("b_reset_count", b_cnt, 8);
        b_kill = 8'h7F;
        step();
        b_kill = '0;
        #1;
`ifdef ENEMIES_BLINK_EN
        check("b_dying_rgb", b_ergb, 8'h01);
        check("b_dying_bus", b_bus, 8'h00);
        for (int i = 0; i < 16; i++) pulse_b_sof();
`endif
        check("b_last_rgb", b_ergb, 8'h08);
        check("b_last_bus", b_bus, 8'h80);
        check("b_last_dr", b_edr, 1);
        step();
        check("b_mask_one", b_mask, 8'h80);
        check("b_count_one", b_cnt, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check("b_rst_mask", b_mask, 8'hFF);
        check("b_rst_count", b_cnt, 8);

        // ---- 3-enemy instance: reset state
        a_dr  = 3'b111;
        a_rgb = {8'h33, 8'h22, 8'h11};
        #1;
        check("a_reset_rgb", a_ergb, 8'h11);
        check("a_reset_bus", a_bus, 3'b001);
        check("a_reset_dr", a_edr, 1);
        check("a_reset_count", a_cnt, 3);
        check("a_reset_mask", a_mask, 3'b111);
        check("a_reset_lc", a_lc, 0);

`ifdef ENEMIES_BLINK_EN
        // kill enemy 0: blink cnt 4 (shown), 3 (hidden), 2 (shown), 1 (hidden), dead
        kill_a(3'b001);
        check("a_k0_rgb", a_ergb, 8'h11);
        check("a_k0_bus", a_bus, 3'b000);
        check("a_k0_count_lag", a_cnt, 3);
        step();
        check("a_k0_count", a_cnt, 2);
        check("a_k0_mask", a_mask, 3'b110);
        pulse_a_sof();
        check("a_f1_rgb", a_ergb, 8'h22);
        check("a_f1_bus", a_bus, 3'b010);
        pulse_a_sof();
        check("a_f2_rgb", a_ergb, 8'h11);
        check("a_f2_bus", a_bus, 3'b000);
        pulse_a_sof();
        check("a_f3_rgb", a_ergb, 8'h22);
        pulse_a_sof();
        check("a_f4_rgb", a_ergb, 8'h22);
        check("a_f4_bus", a_bus, 3'b010);
        a_dr = 3'b001;
        #1;
        check("a_dead0_dr", a_edr, 0);

        // second kill mid-blink on enemy 1 must not reload the counter
        a_dr = 3'b010;
        kill_a(3'b010);
        check("a_k1_vis", a_edr, 1);
        pulse_a_sof();
        kill_a(3'b010);
        pulse_a_sof();
        check("a_rekill_vis", a_edr, 1);
        check("a_rekill_bus", a_bus, 3'b000);
        pulse_a_sof();
        check("a_rekill_hidden", a_edr, 0);
        pulse_a_sof();
        check("a_rekill_dead", a_edr, 0);

        // kill enemy 2 (last non-dead one): level_clear after its death
        a_dr = 3'b100;
        kill_a(3'b100);
        check("a_k2_vis", a_edr, 1);
        for (int i = 0; i < 4; i++) pulse_a_sof();
        check("a_lc_early", a_lc, 0);
        step();
        check("a_lc_pulse", a_lc, 1);
        check("a_all_dead_count", a_cnt, 0);
        step();
        check("a_lc_end", a_lc, 0);
`else
        kill_a(3'b001);
        check("a_k0_bus", a_bus, 3'b010);
        check("a_k0_rgb", a_ergb, 8'h22);
        check("a_k0_count_lag", a_cnt, 3);
        step();
        check("a_k0_count", a_cnt, 2);
        check("a_k0_mask", a_mask, 3'b110);
`endif

        // re-arm coincides with a kill on enemy 1: re-arm wins
        a_dr = 3'b010;
        a_game_on = 1'b1;
        kill_a(3'b010);
        check("a_rearm_bus", a_bus, 3'b010);
        check("a_rearm_rgb", a_ergb, 8'h22);
        a_dr = 3'b111;
        #1;
        check("a_rearm_rgb0", a_ergb, 8'h11);
        check("a_rearm_bus0", a_bus, 3'b001);
        step();
        check("a_rearm_count", a_cnt, 3);
        check("a_rearm_mask", a_mask, 3'b111);

        // simultaneous kill of all three: one level_clear pulse
        kill_a(3'b111);
        check("a_kall_bus", a_bus, 3'b000);
`ifdef ENEMIES_BLINK_EN
        for (int i = 0; i < 4; i++) pulse_a_sof();
`endif
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (a_lc === 1'b1) pulses++;
            step();
        end
        check("a_kall_pulses", pulses, 1);
        check("a_kall_count", a_cnt, 0);
        check("a_kall_dr", a_edr, 0);
        check("a_kall_rgb", a_ergb, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
